axi4_lite_slave_mem: RTL and testbench
======================================

Name: axi4_lite_slave_mem

Overview:
AXI4-Lite slave endpoint that terminates the AXI4-Lite signal bundle driven by the master VIP/back-to-back testbench.
It consumes the AW/W/AR channels and produces the B/R channels.
It backs accesses with a small word-addressed, byte-enabled memory so master-side sequences have a real, checkable target.

Parameters:
ADDRESS_WIDTH, 32, address bus width; same value as the globals package.
DATA_WIDTH, 32, data bus width, 32 or 64; same value as the globals package.
MEM_DEPTH, 16, number of DATA_WIDTH-wide words; power of two, minimum 2.
BASE_ADDR, 0, byte address of word 0; must be aligned to MEM_DEPTH*DATA_WIDTH/8.

Ports:
aclk  in  1  clock
aresetn  in  1  asynchronous active-low reset
awaddr  in  ADDRESS_WIDTH  write address
awprot  in  3  write protection
awvalid  in  1  write address valid
awready  out  1  write address ready
wdata  in  DATA_WIDTH  write data
wstrb  in  DATA_WIDTH/8  byte strobes
wvalid  in  1  write data valid
wready  out  1  write data ready
bresp  out  2  write response
bvalid  out  1  write response valid
bready  in  1  write response ready
araddr  in  ADDRESS_WIDTH  read address
arprot  in  3  read protection
arvalid  in  1  read address valid
arready  out  1  read address ready
rdata  out  DATA_WIDTH  read data
rresp  out  2  read response
rvalid  out  1  read data valid
rready  in  1  read data ready

Behaviour:
- Interface: one clock `aclk`; reset `aresetn` is asynchronous, active-low.
- Reset: all outputs are registered and reset to 0 (awready, wready, arready, bvalid, rvalid, bresp, rresp, rdata). Memory contents are not reset.
- Readiness after reset: awready, wready and arready rise in the first cycle after aresetn deasserts.
- Reset mid-transaction: aborts it, drops all pending state, and leaves memory unchanged unless the commit edge has already passed.

- Write FSM states: W_IDLE, W_HAVE_AW, W_HAVE_W, W_RESP.
  - W_IDLE: awready=wready=1.
    - AW and W handshake in the same cycle -> commit, then W_RESP.
    - AW only -> latch address, drop awready, go to W_HAVE_AW.
    - W only -> latch data and strobe, drop wready, go to W_HAVE_W.
  - W_HAVE_AW: wready=1. W handshake -> commit, then W_RESP.
  - W_HAVE_W: awready=1. AW handshake -> commit, then W_RESP.
  - Commit: the memory write occurs on the edge that completes the second handshake. bvalid=1 in the following cycle.
  - W_RESP: awready=wready=0; bvalid held with bresp stable until bready=1, then W_IDLE. A new AW/W is accepted no earlier than the cycle after the B handshake.
- Write data, strobes and decode:
  - Byte lane i is written only if wstrb[i]=1. wstrb=0 is a legal no-op that returns OKAY.
  - Decode: word index = (addr - BASE_ADDR) >> log2(DATA_WIDTH/8). Low address bits are ignored, so unaligned addresses round down.
  - addr outside [BASE_ADDR, BASE_ADDR + MEM_DEPTH*DATA_WIDTH/8) -> no memory write, bresp = SLVERR (2'b10). Otherwise bresp = OKAY (2'b00).

- Read FSM states: R_IDLE, R_RESP.
  - R_IDLE: arready=1. AR handshake -> sample memory on that edge, rvalid=1 in the next cycle (latency 1), go to R_RESP.
  - R_RESP: arready=0; rvalid, rdata and rresp stable until rready=1, then R_IDLE.
  - Read decode is identical to write decode. Out-of-range -> rresp = SLVERR, rdata = 0.
- Read/write independence:
  - Read and write channels are fully independent and may complete in the same cycle.
  - Same-word AR handshake on the write commit edge returns the OLD data (read-before-write).
- awprot/arprot are ignored unless the optional feature is compiled in.

Optional Feature:
AXI4_LITE_SLAVE_PROT_CHECK_EN
- Defined: an access with prot[0]=0 (unprivileged) receives SLVERR.
  - Write: no memory write.
  - Read: rdata = 0.
  - Out-of-range still returns SLVERR; the two errors are not distinguished.
- Undefined: awprot/arprot are unused and all in-range accesses return OKAY.

Decomposition:
- Axi4LiteGlobalsPkg additions:
  - response typedef enum logic [1:0]: OKAY=0, EXOKAY=1, SLVERR=2, DECERR=3.
  - Write and read FSM state enums.
  - Existing ADDRESS_WIDTH and DATA_WIDTH.
- One sub-module, axi4_lite_slave_mem_array:
  - MEM_DEPTH x DATA_WIDTH storage.
  - One byte-enabled synchronous write port and one synchronous read port.
  - Read-before-write on a same-cycle, same-address collision.

Test Plan:
- AW and W in the same cycle: awaddr=0x4, wdata=0xDEADBEEF, wstrb=0xF, bready=1 -> bvalid one cycle later with bresp=0. Then AR 0x4 -> rvalid one cycle after the AR handshake, rdata=0xDEADBEEF, rresp=0.
- W three cycles before AW (awaddr=0x8, wdata=0x11223344, wstrb=0x5) over a word preloaded with 0xFFFFFFFF -> single B response; a later read of 0x8 returns 0xFF22FF44.
- Backpressure: bready=0 for 5 cycles -> bvalid and bresp stable throughout, awready=wready=0 throughout. Same check for rready=0 on the read channel.
- Out-of-range write and read to 0x40 (MEM_DEPTH=16, BASE_ADDR=0) -> bresp=2 with memory unchanged, rresp=2 with rdata=0.
- Simultaneous write commit and AR to 0xC (old 0x0, new 0x5A5A5A5A) -> read returns 0x0; a subsequent read returns 0x5A5A5A5A.
- aresetn pulsed low while in W_HAVE_AW -> all outputs 0 asynchronously. After release a fresh write completes normally, and the aborted write never lands in memory.

Source files
------------

// File: rtl/axi4_lite_slave_mem_pkg.sv
// Shared definitions for the AXI4-Lite memory slave: bus widths, response codes and FSM state types.
package axi4_lite_slave_mem_pkg;

    localparam int ADDRESS_WIDTH = 32;
    localparam int DATA_WIDTH    = 32;

    typedef enum logic [1:0] {
        OKAY   = 2'b00,
        EXOKAY = 2'b01,
        SLVERR = 2'b10,
        DECERR = 2'b11
    } axi_resp_e;

    typedef enum logic [1:0] {
        W_IDLE,
        W_HAVE_AW,
        W_HAVE_W,
        W_RESP
    } wr_state_e;

    typedef enum logic {
        R_IDLE,
        R_RESP
    } rd_state_e;

endpackage

// File: rtl/axi4_lite_slave_mem_if.sv
// AXI4-Lite signal bundle (AW/W/B/AR/R) with master and slave views.
interface axi4_lite_slave_mem_if
    import axi4_lite_slave_mem_pkg::*;
#(
    parameter int ADDR_W = ADDRESS_WIDTH,
    parameter int DATA_W = DATA_WIDTH
);
    logic [ADDR_W-1:0]   awaddr;
    logic [2:0]          awprot;
    logic                awvalid;
    logic                awready;
    logic [DATA_W-1:0]   wdata;
    logic [DATA_W/8-1:0] wstrb;
    logic                wvalid;
    logic                wready;
    logic [1:0]          bresp;
    logic                bvalid;
    logic                bready;
    logic [ADDR_W-1:0]   araddr;
    logic [2:0]          arprot;
    logic                arvalid;
    logic                arready;
    logic [DATA_W-1:0]   rdata;
    logic [1:0]          rresp;
    logic                rvalid;
    logic                rready;

    modport master (
        output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
               araddr, arprot, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

    modport slave (
        input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
               araddr, arprot, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

endinterface

// File: rtl/axi4_lite_slave_mem_array.sv
// Word storage with one byte-enabled write port and one registered read port.
// Latency: read data valid the cycle after rd_en; same-edge write to the read word returns old data.
// Backpressure: none; the caller only pulses rd_en when it can hold the result.
module axi4_lite_slave_mem_array #(
    parameter int MEM_DEPTH  = 16,
    parameter int DATA_WIDTH = 32
) (
    input  logic                          aclk,
    input  logic                          aresetn,
    input  logic                          wr_en,
    input  logic [$clog2(MEM_DEPTH)-1:0]  wr_idx,
    input  logic [DATA_WIDTH-1:0]         wr_data,
    input  logic [DATA_WIDTH/8-1:0]       wr_strb,
    input  logic                          rd_en,
    input  logic                          rd_zero,
    input  logic [$clog2(MEM_DEPTH)-1:0]  rd_idx,
    output logic [DATA_WIDTH-1:0]         rd_data
);
    localparam int STRB_W = DATA_WIDTH / 8;

    logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];
    logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;

    // Storage is deliberately unreset; only the read register clears.
    always_ff @(posedge aclk) begin
        if (wr_en) begin
            for (int i = 0; i < STRB_W; i++) begin
                if (wr_strb[i]) begin
                    mem[wr_idx][8*i +: 8] <= wr_data[8*i +: 8];
                end
            end
        end
    end

    always_comb begin
        rd_data_d = rd_data_q;
        if (rd_en) begin
            rd_data_d = rd_zero ? '0 : mem[rd_idx];
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            rd_data_q <= '0;
        end else begin
            rd_data_q <= rd_data_d;
        end
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/axi4_lite_slave_mem.sv
// AXI4-Lite slave backed by a byte-enabled word memory; AXI4_LITE_SLAVE_PROT_CHECK_EN rejects unprivileged accesses.
// Latency: B one cycle after the second of AW/W is accepted, R one cycle after AR.
// Backpressure: B/R held stable until bready/rready; no new request on that channel until then.
module axi4_lite_slave_mem #(
    parameter int ADDRESS_WIDTH = axi4_lite_slave_mem_pkg::ADDRESS_WIDTH,
    parameter int DATA_WIDTH    = axi4_lite_slave_mem_pkg::DATA_WIDTH,
    parameter int MEM_DEPTH     = 16,
    parameter logic [ADDRESS_WIDTH-1:0] BASE_ADDR = '0
) (
    input  logic                 aclk,
    input  logic                 aresetn,
    axi4_lite_slave_mem_if.slave s_axi
);
    import axi4_lite_slave_mem_pkg::*;

    localparam int STRB_W = DATA_WIDTH / 8;
    localparam int OFF_W  = $clog2(STRB_W);
    localparam int IDX_W  = $clog2(MEM_DEPTH);
    localparam logic [ADDRESS_WIDTH-1:0] MEM_BYTES = ADDRESS_WIDTH'(MEM_DEPTH * STRB_W);

    wr_state_e                wr_state_q, wr_state_d;
    logic                     awready_q, awready_d;
    logic                     wready_q, wready_d;
    logic                     bvalid_q, bvalid_d;
    axi_resp_e                bresp_q, bresp_d;
    logic [ADDRESS_WIDTH-1:0] awaddr_q, awaddr_d;
    logic                     awpriv_q, awpriv_d;
    logic [DATA_WIDTH-1:0]    wdata_q, wdata_d;
    logic [STRB_W-1:0]        wstrb_q, wstrb_d;

    rd_state_e                rd_state_q, rd_state_d;
    logic                     arready_q, arready_d;
    logic                     rvalid_q, rvalid_d;
    axi_resp_e                rresp_q, rresp_d;

    logic                     aw_hs, w_hs, ar_hs;
    logic                     wr_commit, mem_we, mem_re;
    logic [ADDRESS_WIDTH-1:0] wr_addr, wr_off, rd_off;
    logic                     wr_priv, wr_priv_ok, rd_priv_ok;
    logic                     wr_ok, rd_ok;
    logic [DATA_WIDTH-1:0]    wr_data;
    logic [STRB_W-1:0]        wr_strb;
    logic [DATA_WIDTH-1:0]    mem_rdata;
    logic                     unused_prot;

    assign aw_hs = s_axi.awvalid & awready_q;
    assign w_hs  = s_axi.wvalid  & wready_q;
    assign ar_hs = s_axi.arvalid & arready_q;

    // Whichever half arrived first was latched; the other comes straight off the bus.
    assign wr_addr = (wr_state_q == W_HAVE_AW) ? awaddr_q : s_axi.awaddr;
    assign wr_priv = (wr_state_q == W_HAVE_AW) ? awpriv_q : s_axi.awprot[0];
    assign wr_data = (wr_state_q == W_HAVE_W)  ? wdata_q  : s_axi.wdata;
    assign wr_strb = (wr_state_q == W_HAVE_W)  ? wstrb_q  : s_axi.wstrb;

    // Offsets wrap for addresses below BASE_ADDR, so one unsigned compare bounds both ends.
    assign wr_off = wr_addr - BASE_ADDR;
    assign rd_off = s_axi.araddr - BASE_ADDR;

`ifdef AXI4_LITE_SLAVE_PROT_CHECK_EN
    assign wr_priv_ok  = wr_priv;
    assign rd_priv_ok  = s_axi.arprot[0];
    assign unused_prot = ^{s_axi.awprot[2:1], s_axi.arprot[2:1]};
`else
    assign wr_priv_ok  = 1'b1;
    assign rd_priv_ok  = 1'b1;
    assign unused_prot = ^{wr_priv, s_axi.awprot[2:1], s_axi.arprot};
`endif

    assign wr_ok = (wr_off < MEM_BYTES) && wr_priv_ok;
    assign rd_ok = (rd_off < MEM_BYTES) && rd_priv_ok;

    always_comb begin
        wr_state_d = wr_state_q;
        awaddr_d   = awaddr_q;
        awpriv_d   = awpriv_q;
        wdata_d    = wdata_q;
        wstrb_d    = wstrb_q;
        bresp_d    = bresp_q;
        wr_commit  = 1'b0;
        mem_we     = 1'b0;

        case (wr_state_q)
            W_IDLE: begin
                if (aw_hs && w_hs) begin
                    wr_commit = 1'b1;
                end else if (aw_hs) begin
                    awaddr_d   = s_axi.awaddr;
                    awpriv_d   = s_axi.awprot[0];
                    wr_state_d = W_HAVE_AW;
                end else if (w_hs) begin
                    wdata_d    = s_axi.wdata;
                    wstrb_d    = s_axi.wstrb;
                    wr_state_d = W_HAVE_W;
                end
            end
            W_HAVE_AW: wr_commit = w_hs;
            W_HAVE_W:  wr_commit = aw_hs;
            W_RESP: begin
                if (s_axi.bready) begin
                    wr_state_d = W_IDLE;
                end
            end
            default: wr_state_d = W_IDLE;
        endcase

        if (wr_commit) begin
            mem_we     = wr_ok;
            bresp_d    = wr_ok ? OKAY : SLVERR;
            wr_state_d = W_RESP;
        end

        awready_d = (wr_state_d == W_IDLE) || (wr_state_d == W_HAVE_W);
        wready_d  = (wr_state_d == W_IDLE) || (wr_state_d == W_HAVE_AW);
        bvalid_d  = (wr_state_d == W_RESP);
    end

    always_comb begin
        rd_state_d = rd_state_q;
        rresp_d    = rresp_q;
        mem_re     = 1'b0;

        case (rd_state_q)
            R_IDLE: begin
                if (ar_hs) begin
                    mem_re     = 1'b1;
                    rresp_d    = rd_ok ? OKAY : SLVERR;
                    rd_state_d = R_RESP;
                end
            end
            R_RESP: begin
                if (s_axi.rready) begin
                    rd_state_d = R_IDLE;
                end
            end
            default: rd_state_d = R_IDLE;
        endcase

        arready_d = (rd_state_d == R_IDLE);
        rvalid_d  = (rd_state_d == R_RESP);
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            wr_state_q <= W_IDLE;
            awready_q  <= 1'b0;
            wready_q   <= 1'b0;
            bvalid_q   <= 1'b0;
            bresp_q    <= OKAY;
            awaddr_q   <= '0;
            awpriv_q   <= 1'b0;
            wdata_q    <= '0;
            wstrb_q    <= '0;
            rd_state_q <= R_IDLE;
            arready_q  <= 1'b0;
            rvalid_q   <= 1'b0;
            rresp_q    <= OKAY;
        end else begin
            wr_state_q <= wr_state_d;
            awready_q  <= awready_d;
            wready_q   <= wready_d;
            bvalid_q   <= bvalid_d;
            bresp_q    <= bresp_d;
            awaddr_q   <= awaddr_d;
            awpriv_q   <= awpriv_d;
            wdata_q    <= wdata_d;
            wstrb_q    <= wstrb_d;
            rd_state_q <= rd_state_d;
            arready_q  <= arready_d;
            rvalid_q   <= rvalid_d;
            rresp_q    <= rresp_d;
        end
    end

    axi4_lite_slave_mem_array #(
        .MEM_DEPTH  (MEM_DEPTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_array (
        .aclk    (aclk),
        .aresetn (aresetn),
        .wr_en   (mem_we),
        .wr_idx  (wr_off[OFF_W +: IDX_W]),
        .wr_data (wr_data),
        .wr_strb (wr_strb),
        .rd_en   (mem_re),
        .rd_zero (!rd_ok),
        .rd_idx  (rd_off[OFF_W +: IDX_W]),
        .rd_data (mem_rdata)
    );

    assign s_axi.awready = awready_q;
    assign s_axi.wready  = wready_q;
    assign s_axi.bvalid  = bvalid_q;
    assign s_axi.bresp   = bresp_q;
    assign s_axi.arready = arready_q;
    assign s_axi.rvalid  = rvalid_q;
    assign s_axi.rresp   = rresp_q;
    assign s_axi.rdata   = mem_rdata;

endmodule

// File: tb/tb_axi4_lite_slave_mem.sv
// Self-checking bench for axi4_lite_slave_mem: directed table, multi-cycle corner sequences, random traffic vs. a word-array model.
module tb_axi4_lite_slave_mem;

    localparam logic [31:0] TB_BASE  = 32'h0;
    localparam logic [31:0] TB_BYTES = 32'd64;

    logic aclk;
    logic aresetn;
    int   checks;
    int   errors;

    logic [31:0] ref_mem [16];

    axi4_lite_slave_mem_if bus ();

    axi4_lite_slave_mem #(
        .ADDRESS_WIDTH (32),
        .DATA_WIDTH    (32),
        .MEM_DEPTH     (16),
        .BASE_ADDR     (TB_BASE)
    ) dut (
        .aclk    (aclk),
        .aresetn (aresetn),
        .s_axi   (bus)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic timeout_fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s: handshake timed out", name);
    endtask

    task automatic step();
        @(posedge aclk);
        #1;
    endtask

    // Reference model: flat array of words, indexed by byte offset / 4.
    function automatic bit ref_ok(input logic [31:0] addr, input logic [2:0] prot);
        bit ok;
        ok = (addr - TB_BASE) < TB_BYTES;
`ifdef AXI4_LITE_SLAVE_PROT_CHECK_EN
        ok = ok && prot[0];
`endif
        return ok;
    endfunction

    task automatic ref_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                             input logic [2:0] prot, output logic [1:0] resp);
        int idx;
        resp = 2'd2;
        if (ref_ok(addr, prot)) begin
            resp = 2'd0;
            idx = int'((addr - TB_BASE) / 4);
            for (int b = 0; b < 4; b++) begin
                if (strb[b]) ref_mem[idx][8*b +: 8] = data[8*b +: 8];
            end
        end
    endtask

    task automatic ref_read(input logic [31:0] addr, input logic [2:0] prot,
                            output logic [31:0] data, output logic [1:0] resp);
        data = 32'h0;
        resp = 2'd2;
        if (ref_ok(addr, prot)) begin
            data = ref_mem[int'((addr - TB_BASE) / 4)];
            resp = 2'd0;
        end
    endtask

    // lead > 0: W is offered lead cycles before AW; lead < 0: AW first; 0: together.
    task automatic do_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                            input logic [2:0] prot, input int lead, output logic [1:0] resp);
        bit aw_done, w_done, hs_aw, hs_w;
        int c;
        aw_done = 0;
        w_done  = 0;
        c       = 0;
        resp    = 2'b11;
        bus.awaddr = addr;
        bus.awprot = prot;
        bus.wdata  = data;
        bus.wstrb  = strb;
        while (!(aw_done && w_done)) begin
            if (!aw_done && c >= ((lead > 0) ? lead : 0)) bus.awvalid = 1'b1;
            if (!w_done && c >= ((lead < 0) ? -lead : 0)) bus.wvalid = 1'b1;
            hs_aw = bus.awvalid && bus.awready;
            hs_w  = bus.wvalid && bus.wready;
            step();
            c++;
            if (hs_aw) begin bus.awvalid = 1'b0; aw_done = 1; end
            if (hs_w)  begin bus.wvalid  = 1'b0; w_done  = 1; end
            if (c > 40) begin
                timeout_fail("write_handshake");
                bus.awvalid = 1'b0;
                bus.wvalid  = 1'b0;
                return;
            end
        end
        check("b_latency", 32'(bus.bvalid), 1);
        resp = bus.bresp;
        bus.bready = 1'b1;
        step();
        bus.bready = 1'b0;
        check("b_single", 32'(bus.bvalid), 0);
    endtask

    task automatic do_read(input logic [31:0] addr, input logic [2:0] prot,
                           output logic [31:0] data, output logic [1:0] resp);
        bit hs;
        int c;
        c    = 0;
        data = 32'h0;
        resp = 2'b11;
        bus.araddr  = addr;
        bus.arprot  = prot;
        bus.arvalid = 1'b1;
        forever begin
            hs = bus.arvalid && bus.arready;
            step();
            c++;
            if (hs) break;
            if (c > 40) begin
                timeout_fail("read_handshake");
                bus.arvalid = 1'b0;
                return;
            end
        end
        bus.arvalid = 1'b0;
        check("r_latency", 32'(bus.rvalid), 1);
        data = bus.rdata;
        resp = bus.rresp;
        bus.rready = 1'b1;
        step();
        bus.rready = 1'b0;
        check("r_single", 32'(bus.rvalid), 0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_awready"}, 32'(bus.awready), 0);
        check({tag, "_wready"},  32'(bus.wready),  0);
        check({tag, "_arready"}, 32'(bus.arready), 0);
        check({tag, "_bvalid"},  32'(bus.bvalid),  0);
        check({tag, "_rvalid"},  32'(bus.rvalid),  0);
        check({tag, "_bresp"},   32'(bus.bresp),   0);
        check({tag, "_rresp"},   32'(bus.rresp),   0);
        check({tag, "_rdata"},   bus.rdata,        0);
    endtask

    typedef struct {
        bit          is_wr;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
        int          lead;
        logic [1:0]  exp_resp;
        logic [31:0] exp_rdata;
    } vec_t;

    initial begin
        vec_t        vecs[15];
        logic [1:0]  resp, mresp;
        logic [31:0] rdata, mdata;

        checks = 0;
        errors = 0;

        // Word i preloads to 0x10203040 + i*0x01010101 (word 1 = 0x11213141, ... word 15 = 0x1F2F3F4F).
        vecs[0]  = '{1'b1, 32'h04, 32'hDEADBEEF, 4'hF,  0, 2'd0, 32'h0};
        vecs[1]  = '{1'b0, 32'h04, 32'h0,        4'h0,  0, 2'd0, 32'hDEADBEEF};
        vecs[2]  = '{1'b1, 32'h08, 32'hFFFFFFFF, 4'hF,  0, 2'd0, 32'h0};
        vecs[3]  = '{1'b1, 32'h08, 32'h11223344, 4'h5,  3, 2'd0, 32'h0};
        vecs[4]  = '{1'b0, 32'h08, 32'h0,        4'h0,  0, 2'd0, 32'hFF22FF44};
        vecs[5]  = '{1'b1, 32'h40, 32'hCAFEF00D, 4'hF,  0, 2'd2, 32'h0};
        vecs[6]  = '{1'b0, 32'h40, 32'h0,        4'h0,  0, 2'd2, 32'h0};
        vecs[7]  = '{1'b0, 32'h00, 32'h0,        4'h0,  0, 2'd0, 32'h10203040};
        vecs[8]  = '{1'b1, 32'h06, 32'hAABBCCDD, 4'hC, -2, 2'd0, 32'h0};
        vecs[9]  = '{1'b0, 32'h07, 32'h0,        4'h0,  0, 2'd0, 32'hAABBBEEF};
        vecs[10] = '{1'b1, 32'h3C, 32'h12345678, 4'h0,  1, 2'd0, 32'h0};
        vecs[11] = '{1'b0, 32'h3C, 32'h0,        4'h0,  0, 2'd0, 32'h1F2F3F4F};
        vecs[12] = '{1'b0, 32'hFFFFFFFC, 32'h0,  4'h0,  0, 2'd2, 32'h0};
        vecs[13] = '{1'b1, 32'h3F, 32'h99887766, 4'h3,  0, 2'd0, 32'h0};
        vecs[14] = '{1'b0, 32'h3D, 32'h0,        4'h0,  0, 2'd0, 32'h1F2F7766};

        aresetn     = 1'b0;
        bus.awaddr  = '0; bus.awprot = '0; bus.awvalid = 1'b0;
        bus.wdata   = '0; bus.wstrb  = '0; bus.wvalid  = 1'b0;
        bus.bready  = 1'b0;
        bus.araddr  = '0; bus.arprot = '0; bus.arvalid = 1'b0;
        bus.rready  = 1'b0;

        repeat (3) step();
        check_all_zero("reset");
        aresetn = 1'b1;
        check("pre_ready_aw", 32'(bus.awready), 0);
        step();
        check("post_rst_awready", 32'(bus.awready), 1);
        check("post_rst_wready",  32'(bus.wready),  1);
        check("post_rst_arready", 32'(bus.arready), 1);

        for (int i = 0; i < 16; i++) begin
            logic [31:0] v;
            v = 32'h10203040 + 32'(i) * 32'h01010101;
            ref_write(32'(i * 4), v, 4'hF, 3'b001, mresp);
            do_write(32'(i * 4), v, 4'hF, 3'b001, 0, resp);
            check("preload_bresp", 32'(resp), 0);
        end

        for (int i = 0; i < 15; i++) begin
            if (vecs[i].is_wr) begin
                ref_write(vecs[i].addr, vecs[i].data, vecs[i].strb, 3'b001, mresp);
                do_write(vecs[i].addr, vecs[i].data, vecs[i].strb, 3'b001, vecs[i].lead, resp);
                check($sformatf("vec%0d_bresp", i), 32'(resp), 32'(vecs[i].exp_resp));
            end else begin
                do_read(vecs[i].addr, 3'b001, rdata, resp);
                check($sformatf("vec%0d_rresp", i), 32'(resp), 32'(vecs[i].exp_resp));
                check($sformatf("vec%0d_rdata", i), rdata, vecs[i].exp_rdata);
            end
        end

        // B backpressure: response must hold and both write readies stay low.
        bus.awaddr = 32'h10; bus.awprot = 3'b001; bus.wdata = 32'h0BADCAFE; bus.wstrb = 4'hF;
        bus.awvalid = 1'b1; bus.wvalid = 1'b1;
        step();
        bus.awvalid = 1'b0; bus.wvalid = 1'b0;
        ref_write(32'h10, 32'h0BADCAFE, 4'hF, 3'b001, mresp);
        for (int k = 0; k < 5; k++) begin
            check("bstall_bvalid",  32'(bus.bvalid),  1);
            check("bstall_bresp",   32'(bus.bresp),   0);
            check("bstall_awready", 32'(bus.awready), 0);
            check("bstall_wready",  32'(bus.wready),  0);
            step();
        end
        bus.bready = 1'b1;
        step();
        bus.bready = 1'b0;
        check("bstall_release_bvalid",  32'(bus.bvalid),  0);
        check("bstall_release_awready", 32'(bus.awready), 1);

        // R backpressure.
        bus.araddr = 32'h10; bus.arprot = 3'b001; bus.arvalid = 1'b1;
        step();
        bus.arvalid = 1'b0;
        for (int k = 0; k < 5; k++) begin
            check("rstall_rvalid",  32'(bus.rvalid),  1);
            check("rstall_rdata",   bus.rdata,        32'h0BADCAFE);
            check("rstall_rresp",   32'(bus.rresp),   0);
            check("rstall_arready", 32'(bus.arready), 0);
            step();
        end
        bus.rready = 1'b1;
        step();
        bus.rready = 1'b0;
        check("rstall_release_rvalid",  32'(bus.rvalid),  0);
        check("rstall_release_arready", 32'(bus.arready), 1);

        // Write commit and AR on the same edge, same word: read sees the old value.
        ref_write(32'h0C, 32'h0, 4'hF, 3'b001, mresp);
        do_write(32'h0C, 32'h0, 4'hF, 3'b001, 0, resp);
        bus.awaddr = 32'h0C; bus.wdata = 32'h5A5A5A5A; bus.wstrb = 4'hF; bus.awprot = 3'b001;
        bus.araddr = 32'h0C; bus.arprot = 3'b001;
        bus.awvalid = 1'b1; bus.wvalid = 1'b1; bus.arvalid = 1'b1;
        check("coll_ready", {29'd0, bus.awready, bus.wready, bus.arready}, 32'h7);
        step();
        bus.awvalid = 1'b0; bus.wvalid = 1'b0; bus.arvalid = 1'b0;
        check("coll_bvalid", 32'(bus.bvalid), 1);
        check("coll_rvalid", 32'(bus.rvalid), 1);
        check("coll_rdata_old", bus.rdata, 32'h0);
        bus.bready = 1'b1; bus.rready = 1'b1;
        step();
        bus.bready = 1'b0; bus.rready = 1'b0;
        ref_write(32'h0C, 32'h5A5A5A5A, 4'hF, 3'b001, mresp);
        do_read(32'h0C, 3'b001, rdata, resp);
        check("coll_rdata_new", rdata, 32'h5A5A5A5A);

        // Reset while the address half of a write is held.
        bus.awaddr = 32'h14; bus.awprot = 3'b001; bus.awvalid = 1'b1;
        step();
        bus.awvalid = 1'b0;
        check("have_aw_awready", 32'(bus.awready), 0);
        check("have_aw_wready",  32'(bus.wready),  1);
        #2;
        aresetn = 1'b0;
        #1;
        check_all_zero("midrst");
        step();
        step();
        aresetn = 1'b1;
        step();
        check("midrst_awready", 32'(bus.awready), 1);
        check("midrst_wready",  32'(bus.wready),  1);
        ref_write(32'h18, 32'h66666666, 4'hF, 3'b001, mresp);
        do_write(32'h18, 32'h66666666, 4'hF, 3'b001, 2, resp);
        check("midrst_fresh_bresp", 32'(resp), 0);
        do_read(32'h14, 3'b001, rdata, resp);
        check("midrst_aborted_word", rdata, 32'h15253545);
        do_read(32'h18, 3'b001, rdata, resp);
        check("midrst_fresh_word", rdata, 32'h66666666);

        // Random traffic against the model, including out-of-range and unaligned addresses.
        for (int n = 0; n < 200; n++) begin
            logic [31:0] addr, data;
            logic [3:0]  strb;
            logic [2:0]  prot;
            int          lead;
            addr = 32'($urandom_range(0, 19)) * 4 + 32'($urandom_range(0, 3));
            if ($urandom_range(0, 15) == 0) addr = $urandom;
            data = $urandom;
            strb = 4'($urandom_range(0, 15));
            prot = 3'($urandom_range(0, 7));
            lead = int'($urandom_range(0, 6)) - 3;
            if ($urandom_range(0, 1) == 1) begin
                ref_write(addr, data, strb, prot, mresp);
                do_write(addr, data, strb, prot, lead, resp);
                check("rand_bresp", 32'(resp), 32'(mresp));
            end else begin
                ref_read(addr, prot, mdata, mresp);
                do_read(addr, prot, rdata, resp);
                check("rand_rresp", 32'(resp), 32'(mresp));
                check("rand_rdata", rdata, mdata);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
